seg7_scan_driver: RTL and testbench

// - Consumes the 5 BCD digits produced by the binary-to-decimal converter (packed [4:0][7:0]).
// - Drives a time-multiplexed common-anode 7-segment display: one digit lit at a time, scanned round-robin.
// - A snapshot register isolates the display from mid-scan changes; segment and anode outputs are registered.

---
 rtl/seg7_scan_driver.sv | 128 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner fed from a BCD digit snapshot.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 5,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_DIGITS-1:0][7:0] dec_i,
    input  logic                       load_i,
    input  logic                       en_i,
    output logic [6:0]                 seg_o,
    output logic [NUM_DIGITS-1:0]      an_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_DARK = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    logic [NUM_DIGITS-1:0][3:0] snap_reg, snap_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic [IDX_W-1:0]           idx_reg, idx_next;
    logic                       tick;
    logic [NUM_DIGITS-1:0]      blank_mask;
    logic [NUM_DIGITS-1:0]      an_sel;
    logic [NUM_DIGITS-1:0]      an_next;
    logic [6:0]                 seg_next;
    logic [6:0]                 seg_decoded;
    logic [3:0]                 cur_digit;
    logic                       cur_blank;

    // Only the low nibble of each byte is kept; the upper nibble never reaches the decoder.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_snap
            assign snap_next[gi] = load_i ? dec_i[gi][3:0] : snap_reg[gi];
            assign an_sel[gi]    = (idx_reg == IDX_W'(gi));
        end
    endgenerate

`ifdef SEG7_LZ_BLANK_EN
    // zero_above[i] is set when digit i and every digit above it are zero.
    logic [NUM_DIGITS:1] zero_above;
    assign zero_above[NUM_DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_units
                assign blank_mask[gi] = 1'b0;
            end else begin : g_upper
                assign zero_above[gi] = zero_above[gi+1] && (snap_reg[gi] == 4'd0);
                assign blank_mask[gi] = zero_above[gi];
            end
        end
    endgenerate
`else
    assign blank_mask = '0;
`endif

    // Prescaler and digit index only move while the display is enabled.
    assign tick = en_i && (cnt_reg == LAST_CNT);

    always_comb begin
        cnt_next = cnt_reg;
        idx_next = idx_reg;
        if (en_i) begin
            cnt_next = tick ? '0 : cnt_reg + 1'b1;
        end
        if (tick) begin
            idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                cur_digit = snap_reg[i];
                cur_blank = blank_mask[i];
            end
        end
    end

    always_comb begin
        case (cur_digit)
            4'd0:    seg_decoded = 7'h40;
            4'd1:    seg_decoded = 7'h79;
            4'd2:    seg_decoded = 7'h24;
            4'd3:    seg_decoded = 7'h30;
            4'd4:    seg_decoded = 7'h19;
            4'd5:    seg_decoded = 7'h12;
            4'd6:    seg_decoded = 7'h02;
            4'd7:    seg_decoded = 7'h78;
            4'd8:    seg_decoded = 7'h00;
            4'd9:    seg_decoded = 7'h10;
            default: seg_decoded = SEG_DASH;
        endcase
    end

    // A blanked digit keeps its anode active so the scan cadence is unchanged.
    always_comb begin
        an_next  = '1;
        seg_next = SEG_DARK;
        if (en_i) begin
            an_next  = ~an_sel;
            seg_next = cur_blank ? SEG_DARK : seg_decoded;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_reg <= '0;
            cnt_reg  <= '0;
            idx_reg  <= '0;
            an_o     <= '1;
            seg_o    <= SEG_DARK;
        end else begin
            snap_reg <= snap_next;
            cnt_reg  <= cnt_next;
            idx_reg  <= idx_next;
            an_o     <= an_next;
            seg_o    <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a time-based reference model.
// Honours SEG7_LZ_BLANK_EN the same way the design does.
module tb_seg7_scan_driver;

    localparam int N   = 5;
    localparam int DIV = 4;
`ifdef SEG7_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic              clk_i;
    logic              rst_ni;
    logic [N-1:0][7:0] dec_i;
    logic              load_i;
    logic              en_i;
    logic [6:0]        seg_o;
    logic [N-1:0]      an_o;

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .dec_i  (dec_i),
        .load_i (load_i),
        .en_i   (en_i),
        .seg_o  (seg_o),
        .an_o   (an_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Reference model: enabled-cycle count since reset plus the captured digits.
    int unsigned en_cnt;
    logic [3:0]  m_snap [N];
    logic [6:0]  seg_tab [16];
    logic [N-1:0] tab_an  [N];
    logic [6:0]   tab_seg [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        en_cnt = 0;
        for (int i = 0; i < N; i++) m_snap[i] = 4'd0;
    endtask

    function automatic bit is_blank(int k);
        if (!LZ || k == 0) return 1'b0;
        for (int j = k; j < N; j++) begin
            if (m_snap[j] != 4'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic ld, input logic en, input logic [N-1:0][7:0] d, input string tag);
        int k;
        logic [N-1:0] exp_an;
        logic [6:0]   exp_seg;
        dec_i  = d;
        load_i = ld;
        en_i   = en;
        @(posedge clk_i);
        if (en) begin
            k       = int'((en_cnt / DIV) % N);
            exp_an  = ~(N'(1) << k);
            exp_seg = is_blank(k) ? 7'h7F : seg_tab[m_snap[k]];
        end else begin
            exp_an  = '1;
            exp_seg = 7'h7F;
        end
        if (ld) for (int i = 0; i < N; i++) m_snap[i] = d[i][3:0];
        if (en) en_cnt++;
        #1;
        txn++;
        $display("txn %0d %s ld=%0b en=%0b an=%0h seg=%0h", txn, tag, ld, en, an_o, seg_o);
        check({tag, "_an"}, 32'(an_o), 32'(exp_an));
        check({tag, "_seg"}, 32'(seg_o), 32'(exp_seg));
        @(negedge clk_i);
    endtask

    function automatic int model_idx();
        return int'((en_cnt / DIV) % N);
    endfunction

    logic [N-1:0][7:0] d;
    logic [N-1:0][7:0] hold_d;

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        tab_an  = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h0F};
        tab_seg = '{7'h19, 7'h30, 7'h24, 7'h79, (LZ ? 7'h7F : 7'h40)};

        rst_ni = 1'b0;
        load_i = 1'b0;
        en_i   = 1'b0;
        dec_i  = '0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check("reset_an", 32'(an_o), 32'h1F);
        check("reset_seg", 32'(seg_o), 32'h7F);
        rst_ni = 1'b1;

        // Directed scan of {0,1,2,3,4}, compared with both the model and fixed expectations.
        d = {8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        step(1'b1, 1'b0, d, "load");
        for (int c = 0; c < 4 * N * 2; c++) begin
            step(1'b0, 1'b1, d, "scan");
            check("scan_tab_an", 32'(an_o), 32'(tab_an[(c / DIV) % N]));
            check("scan_tab_seg", 32'(seg_o), 32'(tab_seg[(c / DIV) % N]));
        end

        // Non-BCD value and ignored upper nibble.
        d = {8'h37, 8'h96, 8'h52, 8'hF5, 8'hAB};
        step(1'b1, 1'b1, d, "nonbcd_load");
        for (int c = 0; c < 4 * N; c++) step(1'b0, 1'b1, d, "nonbcd");

        // Drop enable for 10 cycles while digit 2 is lit.
        for (int c = 0; c < 40 && model_idx() != 2; c++) step(1'b0, 1'b1, d, "to_dig2");
        step(1'b0, 1'b1, d, "dig2");
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, d, "dark");
            check("dark_an", 32'(an_o), 32'h1F);
            check("dark_seg", 32'(seg_o), 32'h7F);
        end
        for (int c = 0; c < 12; c++) step(1'b0, 1'b1, d, "resume");

        // Load on a tick cycle.
        for (int c = 0; c < 8 && (en_cnt % DIV) != DIV - 1; c++) step(1'b0, 1'b1, d, "to_tick");
        d = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5};
        step(1'b1, 1'b1, d, "collide");
        for (int c = 0; c < 6; c++) step(1'b0, 1'b1, d, "post_collide");

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) d[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d[$urandom_range(0, N - 1)] = 8'h00;
            step(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) != 0), d, "rand");
        end

        // Asynchronous reset in the middle of a scan.
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_an", 32'(an_o), 32'h1F);
        check("async_rst_seg", 32'(seg_o), 32'h7F);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 10; c++) step(1'b0, 1'b1, d, "after_rst");

        // Leading-zero patterns.
        d = {8'd0, 8'd0, 8'd0, 8'd4, 8'd0};
        step(1'b1, 1'b1, d, "lz_load");
        for (int c = 0; c < 4 * N + 4; c++) step(1'b0, 1'b1, d, "lz_a");
        hold_d = '0;
        step(1'b1, 1'b1, hold_d, "lz0_load");
        for (int c = 0; c < 4 * N + 4; c++) begin
            step(1'b0, 1'b1, hold_d, "lz_b");
            if (LZ && an_o != 5'h1E) check("lz_zero_blank", 32'(seg_o), 32'h7F);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
